// File: rtl/flash_pkg.sv
// Shared definitions for the flash read path: address width, read opcode and
// the block-reader FSM state encoding.
package flash_pkg;

    localparam int ADDR_W = 24;
    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_FINISH
    } blk_state_e;

endpackage

// File: rtl/flash_byte_fifo.sv
// First-word fall-through FIFO holding {last, byte} entries for the block reader.
// DEPTH must be a power of two (pointers wrap naturally).
module flash_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the slot in the same cycle, so push is accepted even when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flash_block_reader.sv
// Multi-byte read sequencer in front of the single-byte SPI flash reader.
// Define FLASH_BLK_RD_CSUM_EN to add the per-request modulo-256 checksum output.
module flash_block_reader
    import flash_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [23:0]       req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rd_start,
    output logic [23:0]       rd_addr,
    input  logic              rd_busy,
    input  logic              rd_dout_en,
    input  logic [7:0]        rd_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic              done
`ifdef FLASH_BLK_RD_CSUM_EN
    ,
    output logic [7:0]        csum
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    blk_state_e          state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    remain;
    logic                zero_len;
    logic                last_seen;

    logic                accept;
    logic                push;
    logic                pop;
    logic                pop_last;
    logic [8:0]          fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    assign req_ready = (state == ST_IDLE) && !rd_busy;
    assign accept    = req_valid && req_ready;
    assign push      = rd_dout_en && ((state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE));
    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_dout[7:0];
    assign m_last    = fifo_dout[8];
    assign pop       = m_valid && m_ready;
    assign pop_last  = pop && m_last;

    flash_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({(remain == '0), rd_dout}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Space is reserved at issue time with one read outstanding at most.
    assert property (@(posedge clk) disable iff (!rst_n) push |-> !fifo_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            remain    <= '0;
            zero_len  <= 1'b0;
            last_seen <= 1'b0;
            rd_start  <= 1'b0;
            rd_addr   <= '0;
            done      <= 1'b0;
        end else begin
            rd_start <= 1'b0;
            done     <= 1'b0;
            if (pop_last) begin
                last_seen <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_addr  <= req_addr;
                        remain    <= req_len;
                        last_seen <= 1'b0;
                        zero_len  <= (req_len == '0);
                        // Empty request: pulse done straight away, FINISH only unwinds.
                        if (req_len == '0) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!rd_busy && (fifo_count < CNT_W'(DEPTH))) begin
                        rd_start <= 1'b1;
                        rd_addr  <= cur_addr;
                        cur_addr <= cur_addr + ADDR_W'(1);
                        remain   <= remain - LEN_W'(1);
                        state    <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (rd_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!rd_busy) begin
                        state <= (remain != '0) ? ST_ISSUE : ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (zero_len) begin
                        state <= ST_IDLE;
                    end else if (last_seen || pop_last) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FLASH_BLK_RD_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (accept) begin
            csum <= '0;
        end else if (push) begin
            csum <= csum + rd_dout;
        end
    end
`endif

endmodule

// File: tb/tb_flash_block_reader.sv
// Directed bench for flash_block_reader with a behavioural single-byte reader model.
module tb_flash_block_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        rd_start;
    logic [23:0] rd_addr;
    logic        rd_busy = 1'b0;
    logic        rd_dout_en = 1'b0;
    logic [7:0]  rd_dout = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        done;
`ifdef FLASH_BLK_RD_CSUM_EN
    logic [7:0]  csum;
`endif

    int unsigned n_checks = 0;
    int unsigned n_bad = 0;

    logic [23:0] starts[$];
    logic [8:0]  pops[$];
    int unsigned done_cnt = 0;

    always #5 clk = ~clk;

    flash_block_reader #(
        .DEPTH (4),
        .LEN_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .rd_start   (rd_start),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .rd_dout_en (rd_dout_en),
        .rd_dout    (rd_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .done       (done)
`ifdef FLASH_BLK_RD_CSUM_EN
        ,
        .csum       (csum)
`endif
    );

    // Byte reader model: no reset, busy 330 cycles, data strobe on cycle 320.
    int unsigned mdl_cnt = 0;
    logic [23:0] mdl_addr = '0;
    always @(posedge clk) begin
        rd_dout_en <= 1'b0;
        if (rd_busy) begin
            mdl_cnt <= mdl_cnt + 1;
            if (mdl_cnt == 320) begin
                rd_dout_en <= 1'b1;
                rd_dout    <= mdl_addr[7:0] ^ 8'hA5;
            end
            if (mdl_cnt == 330) begin
                rd_busy <= 1'b0;
            end
        end else if (rd_start) begin
            rd_busy  <= 1'b1;
            mdl_cnt  <= 1;
            mdl_addr <= rd_addr;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_start) starts.push_back(rd_addr);
            if (m_valid && m_ready) pops.push_back({m_last, m_data});
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        starts.delete();
        pops.delete();
        done_cnt = 0;
    endtask

    task automatic accept(input logic [23:0] addr, input logic [15:0] len);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("accept_ready", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int unsigned max);
        bit ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic check_stream(input string tag, input logic [23:0] base, input int n);
        logic [23:0] a;
        logic [8:0]  e;
        check({tag, "_nstart"}, starts.size(), n);
        check({tag, "_npop"}, pops.size(), n);
        check({tag, "_ndone"}, done_cnt, 1);
        for (int i = 0; i < n; i++) begin
            a = base + 24'(i);
            e = {(i == n - 1), a[7:0] ^ 8'hA5};
            if (i < starts.size()) check($sformatf("%s_addr%0d", tag, i), starts[i], a);
            if (i < pops.size())   check($sformatf("%s_byte%0d", tag, i), pops[i], e);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_bytes [4];
        logic [7:0] sum;
        bit ok;
        exp_bytes = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

        repeat (3) @(negedge clk);
        check("rst_start", rd_start, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_done", done, 0);
        check("rst_ready", req_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 4 bytes from 0x100, consumer always ready
        clear_log();
        accept(24'h000100, 16'd4);
        @(negedge clk);
        check("t1_start_t1", rd_start, 0);
        @(negedge clk);
        check("t1_start_t2", rd_start, 1);
        check("t1_addr_t2", rd_addr, 24'h000100);
        wait_done("t1", 3000);
        check_stream("t1", 24'h000100, 4);
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum = sum + exp_bytes[i];
            if (i < pops.size()) check($sformatf("t1_tbl%0d", i), pops[i][7:0], exp_bytes[i]);
        end
`ifdef FLASH_BLK_RD_CSUM_EN
        check("t1_csum", csum, sum);
`endif

        // zero-length request
        clear_log();
        accept(24'h000040, 16'd0);
        @(negedge clk);
        check("t2_done_t1", done, 1);
        repeat (5) @(negedge clk);
        check("t2_nstart", starts.size(), 0);
        check("t2_valid", m_valid, 0);
        check("t2_ndone", done_cnt, 1);

        // address wrap across 0xFFFFFF
        clear_log();
        accept(24'hFFFFFE, 16'd3);
        wait_done("t3", 3000);
        check_stream("t3", 24'hFFFFFE, 3);
        if (starts.size() == 3) check("t3_wrap", starts[2], 24'h000000);

        // consumer stalled: FIFO fills, then issue stalls
        clear_log();
        m_ready = 1'b0;
        accept(24'h000200, 16'd8);
        repeat (3000) @(negedge clk);
        check("t4_stall_nstart", starts.size(), 4);
        check("t4_stall_valid", m_valid, 1);
        check("t4_stall_data", m_data, 8'hA5);
        check("t4_stall_last", m_last, 0);
        check("t4_stall_busy", rd_busy, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_done("t4", 4000);
        check_stream("t4", 24'h000200, 8);

        // reset while the byte reader is busy
        clear_log();
        accept(24'h000300, 16'd2);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_busy_seen", {31'd0, ok}, 32'd1);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        @(negedge clk);
        check("t5_ready_low", req_ready, 0);
        check("t5_busy_still", rd_busy, 1);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!rd_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_busy_fell", {31'd0, ok}, 32'd1);
        check("t5_ready_high", req_ready, 1);
        repeat (3) @(negedge clk);
        check("t5_stale_valid", m_valid, 0);
        check("t5_stale_npop", pops.size(), 0);
        accept(24'h000010, 16'd1);
        wait_done("t5", 2000);
        check_stream("t5", 24'h000010, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
